// File: rtl/bus_mux_nch_reg.sv
// Registered N-channel bus-source selector for Bus_1 with direct and round-robin modes.
// One output slot with a valid/ready handshake; bad direct selects raise a sticky error.
module bus_mux_nch_reg #(
    parameter int WS  = 8,
    parameter int NCH = 5,
    parameter int SW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*WS-1:0] data_in,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    input  logic              sel_valid,
    input  logic [NCH-1:0]    req,
    input  logic              out_ready,
    input  logic              err_clr,
    output logic [WS-1:0]     mux_out,
    output logic              out_valid,
    output logic [NCH-1:0]    grant,
    output logic              sel_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [SW:0]   NCH_EXT = (SW+1)'(NCH);
    localparam logic [SW-1:0] LAST_CH = SW'(NCH-1);

    state_t            state_reg, state_next;
    logic [WS-1:0]     mux_out_reg, mux_out_next;
    logic [NCH-1:0]    grant_reg, grant_next;
    logic              sel_err_reg, sel_err_next;
    logic [SW-1:0]     rr_ptr_reg, rr_ptr_next;

    logic [WS-1:0]     ch [NCH];
    logic              rr_found;
    logic [SW-1:0]     rr_winner;
    logic [SW:0]       rr_idx;
    logic              sel_ok;
    logic              dir_hit;
    logic              dir_err;
    logic              rr_hit;
    logic              slot_free;
    logic              capture;
    logic [SW-1:0]     cap_idx;
    logic [WS-1:0]     cap_word;
    logic [NCH-1:0]    cap_onehot;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign ch[gi]         = data_in[gi*WS +: WS];
            assign cap_onehot[gi] = (cap_idx == SW'(gi));
        end
    endgenerate

    // Scan rr_ptr, rr_ptr+1, ... with wrap; first requesting channel wins.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        rr_idx    = '0;
        for (int i = 0; i < NCH; i++) begin
            rr_idx = {1'b0, rr_ptr_reg} + (SW+1)'(i);
            if (rr_idx >= NCH_EXT) begin
                rr_idx = rr_idx - NCH_EXT;
            end
            for (int k = 0; k < NCH; k++) begin
                if (!rr_found && req[k] && (rr_idx == (SW+1)'(k))) begin
                    rr_found  = 1'b1;
                    rr_winner = SW'(k);
                end
            end
        end
    end

    assign sel_ok    = ({1'b0, sel} < NCH_EXT);
    assign dir_hit   = !mode && sel_valid && sel_ok;
    assign dir_err   = !mode && sel_valid && !sel_ok;
    assign rr_hit    = mode && rr_found;
    assign slot_free = (state_reg == EMPTY) || out_ready;
    assign capture   = slot_free && (dir_hit || rr_hit);
    assign cap_idx   = mode ? rr_winner : sel;

    // Explicit compare-select so an unused out-of-range index can never read X.
    always_comb begin
        cap_word = '0;
        for (int k = 0; k < NCH; k++) begin
            if (cap_idx == SW'(k)) begin
                cap_word = ch[k];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        mux_out_next = mux_out_reg;
        grant_next   = grant_reg;
        rr_ptr_next  = rr_ptr_reg;
        sel_err_next = sel_err_reg;

        if (capture) begin
            state_next   = FULL;
            mux_out_next = cap_word;
            grant_next   = cap_onehot;
            if (mode) begin
                rr_ptr_next = (rr_winner == LAST_CH) ? '0 : rr_winner + SW'(1);
            end
        end else if (slot_free) begin
            // Slot drained (or nothing to take): word stays on the bus, but is no longer valid.
            state_next = EMPTY;
            grant_next = '0;
        end

        if (dir_err) begin
            sel_err_next = 1'b1;
        end else if (err_clr) begin
            sel_err_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= EMPTY;
            mux_out_reg <= '0;
            grant_reg   <= '0;
            sel_err_reg <= 1'b0;
            rr_ptr_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            mux_out_reg <= mux_out_next;
            grant_reg   <= grant_next;
            sel_err_reg <= sel_err_next;
            rr_ptr_reg  <= rr_ptr_next;
        end
    end

    assign mux_out   = mux_out_reg;
    assign out_valid = (state_reg == FULL);
    assign grant     = grant_reg;
    assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_bus_mux_nch_reg.sv
// Directed bench for bus_mux_nch_reg: 5x8-bit instance for modes/errors/reset,
// 8x16-bit instance for the back-to-back select sweep.
module tb_bus_mux_nch_reg;

    logic        clk;
    logic        rst;
    logic [39:0] data_in;
    logic        mode;
    logic [2:0]  sel;
    logic        sel_valid;
    logic [4:0]  req;
    logic        out_ready;
    logic        err_clr;
    logic [7:0]  mux_out;
    logic        out_valid;
    logic [4:0]  grant;
    logic        sel_err;

    logic [127:0] data_in_b;
    logic [2:0]   sel_b;
    logic         sel_valid_b;
    logic         out_ready_b;
    logic [15:0]  mux_out_b;
    logic         out_valid_b;
    logic [7:0]   grant_b;
    logic         sel_err_b;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard entries: {grant[7:0], data[15:0]}
    logic [23:0] sb[$];

    bus_mux_nch_reg #(.WS(8), .NCH(5), .SW(3)) u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .req(req), .out_ready(out_ready), .err_clr(err_clr),
        .mux_out(mux_out), .out_valid(out_valid), .grant(grant), .sel_err(sel_err)
    );

    bus_mux_nch_reg #(.WS(16), .NCH(8), .SW(3)) u_dut16 (
        .clk(clk), .rst(rst), .data_in(data_in_b), .mode(1'b0), .sel(sel_b),
        .sel_valid(sel_valid_b), .req(8'h00), .out_ready(out_ready_b), .err_clr(1'b0),
        .mux_out(mux_out_b), .out_valid(out_valid_b), .grant(grant_b), .sel_err(sel_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] g, input logic [15:0] d);
        sb.push_back({g, d});
    endtask

    task automatic pop_check(input string tag, input logic [7:0] g, input logic [15:0] d);
        logic [23:0] e;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $error("FAIL %s observed data=%h grant=%b expected nothing queued", tag, d, g);
        end else begin
            e = sb.pop_front();
            assert ({g, d} === e) else begin
                n_errors++;
                $error("FAIL %s observed data=%h grant=%b expected data=%h grant=%b",
                       tag, d, g, e[15:0], e[23:16]);
            end
            $display("txn %s data=%h grant=%b", tag, d, g);
        end
    endtask

    initial begin
        rst         = 1'b0;
        data_in     = {8'h44, 8'hA5, 8'h22, 8'h3C, 8'h11};
        mode        = 1'b0;
        sel         = 3'd0;
        sel_valid   = 1'b0;
        req         = 5'b0;
        out_ready   = 1'b0;
        err_clr     = 1'b0;
        data_in_b   = '0;
        sel_b       = 3'd0;
        sel_valid_b = 1'b0;
        out_ready_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            data_in_b[k*16 +: 16] = 16'(16'hB000 + k * 257);
        end

        tick();
        tick();
        chk("rst_mux_out", 32'(mux_out), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_sel_err", 32'(sel_err), 32'h0);
        chk("rst_b_valid", 32'(out_valid_b), 32'h0);

        // Direct capture of channel 3
        rst = 1'b1; mode = 1'b0; sel = 3'd3; sel_valid = 1'b1; out_ready = 1'b1;
        push(8'b0000_1000, 16'h00A5);
        tick();
        chk("d3_valid", 32'(out_valid), 32'h1);
        pop_check("d3", 8'(grant), 16'(mux_out));

        // Stall for three cycles while a new select is pending
        out_ready = 1'b0; sel = 3'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_mux", 32'(mux_out), 32'hA5);
            chk("stall_grant", 32'(grant), 32'b01000);
        end
        out_ready = 1'b1;
        push(8'b0000_0010, 16'h003C);
        tick();
        pop_check("d1_after_stall", 8'(grant), 16'(mux_out));

        // Out-of-range select
        sel = 3'd5;
        tick();
        chk("err5_sel_err", 32'(sel_err), 32'h1);
        chk("err5_valid", 32'(out_valid), 32'h0);
        chk("err5_grant", 32'(grant), 32'h0);
        chk("err5_mux_kept", 32'(mux_out), 32'h3C);
        sel = 3'd6; err_clr = 1'b1;
        tick();
        chk("err_set_wins", 32'(sel_err), 32'h1);
        sel_valid = 1'b0;
        tick();
        chk("err_cleared", 32'(sel_err), 32'h0);
        err_clr = 1'b0; sel = 3'd4; sel_valid = 1'b1;
        push(8'b0001_0000, 16'h0044);
        tick();
        pop_check("d4_last_ch", 8'(grant), 16'(mux_out));

        // Round-robin; sel/sel_valid ignored even when out of range
        mode = 1'b1; req = 5'b10101; sel = 3'd7; sel_valid = 1'b1;
        push(8'b0000_0001, 16'h0011);
        push(8'b0000_0100, 16'h0022);
        push(8'b0001_0000, 16'h0044);
        push(8'b0000_0001, 16'h0011);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_valid", 32'(out_valid), 32'h1);
            pop_check("rr_10101", 8'(grant), 16'(mux_out));
        end
        chk("rr_no_err", 32'(sel_err), 32'h0);
        req = 5'b00010;
        push(8'b0000_0010, 16'h003C);
        tick();
        pop_check("rr_00010", 8'(grant), 16'(mux_out));

        // Stall in FULL, mode change and error while stalled, then reset
        out_ready = 1'b0; req = 5'b00100;
        tick();
        chk("rr_stall_mux", 32'(mux_out), 32'h3C);
        chk("rr_stall_grant", 32'(grant), 32'b00010);
        mode = 1'b0; sel = 3'd6; sel_valid = 1'b1;
        tick();
        chk("stall_err_set", 32'(sel_err), 32'h1);
        chk("stall_err_valid", 32'(out_valid), 32'h1);
        chk("stall_err_grant", 32'(grant), 32'b00010);
        rst = 1'b0;
        tick();
        chk("rst2_mux_out", 32'(mux_out), 32'h0);
        chk("rst2_out_valid", 32'(out_valid), 32'h0);
        chk("rst2_grant", 32'(grant), 32'h0);
        chk("rst2_sel_err", 32'(sel_err), 32'h0);
        rst = 1'b1; mode = 1'b1; req = 5'b10101; out_ready = 1'b1; sel_valid = 1'b0;
        push(8'b0000_0001, 16'h0011);
        tick();
        pop_check("rr_restart", 8'(grant), 16'(mux_out));
        req = 5'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_grant", 32'(grant), 32'h0);
        chk("drain_mux_kept", 32'(mux_out), 32'h11);

        // Wide instance: back-to-back sweep of all eight channels
        out_ready_b = 1'b1; sel_valid_b = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sel_b = 3'(k);
            push(8'(8'b1 << k), 16'(16'hB000 + k * 257));
            tick();
            chk("sweep_valid", 32'(out_valid_b), 32'h1);
            pop_check("sweep16", grant_b, mux_out_b);
        end
        sel_valid_b = 1'b0;
        tick();
        chk("sweep_drain", 32'(out_valid_b), 32'h0);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
